// File: rtl/fb_write_arbiter.sv
// Framebuffer write arbiter: merges single-pixel CPU writes with a
// rectangle-fill engine onto one framebuffer write port, one write per cycle.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | waiting for fill_start; the CPU owns the write port alone
// S_FILL     | fill engine requests one pixel per cycle, shares the port
// S_DONE     | last fill pixel granted; fill_done pulses on the next cycle
module fb_write_arbiter #(
    parameter int H_RES       = 640,
    parameter int V_RES       = 400,
    parameter int PIXEL_COUNT = H_RES * V_RES
) (
    input  logic        cpu_clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [7:0]  cpu_data,
    output logic        cpu_ack,
    input  logic        fill_start,
    input  logic        fill_abort,
    input  logic [9:0]  fill_x0,
    input  logic [9:0]  fill_y0,
    input  logic [9:0]  fill_w,
    input  logic [9:0]  fill_h,
    input  logic [7:0]  fill_color,
    output logic        fill_busy,
    output logic        fill_done,
    output logic        fb_wr,
    output logic [31:0] fb_addr,
    output logic [7:0]  fb_data,
    output logic        err_oob
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [10:0] H_RES11 = 11'(H_RES);
    localparam logic [10:0] V_RES11 = 11'(V_RES);
    localparam logic [31:0] H_RES32 = 32'(H_RES);
    localparam logic [31:0] PC32    = 32'(PIXEL_COUNT);

    logic [1:0]  state, state_nxt;
    logic [10:0] x_cur, y_cur, x0_q, x_end_q, y_end_q;
    logic [31:0] fill_addr, row_base;
    logic [7:0]  color_q;
    logic        last_cpu;

    logic [10:0] x_sum, y_sum, x_end_c, y_end_c;
    logic        region_empty;
    logic [31:0] start_row_base;
    logic        cpu_eligible, fill_req, grant_cpu, grant_fill, cpu_oob;
    logic        last_col, last_row;

    // Clip the requested rectangle to the visible area and form its start row.
    always_comb begin
        x_sum          = {1'b0, fill_x0} + {1'b0, fill_w};
        y_sum          = {1'b0, fill_y0} + {1'b0, fill_h};
        x_end_c        = (x_sum > H_RES11) ? H_RES11 : x_sum;
        y_end_c        = (y_sum > V_RES11) ? V_RES11 : y_sum;
        region_empty   = (x_end_c <= {1'b0, fill_x0}) || (y_end_c <= {1'b0, fill_y0});
        start_row_base = {22'd0, fill_y0} * H_RES32;
    end

    // Per-cycle arbitration; a CPU request is not re-granted while its ack is showing.
    always_comb begin
        cpu_eligible = cpu_req && !cpu_ack;
        fill_req     = (state == S_FILL) && !fill_abort;
        grant_cpu    = cpu_eligible && (!fill_req || !last_cpu);
        grant_fill   = fill_req && !grant_cpu;
        cpu_oob      = (cpu_addr >= PC32);
        last_col     = ((x_cur + 11'd1) == x_end_q);
        last_row     = ((y_cur + 11'd1) == y_end_q);
    end

    // Fill FSM next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (fill_start) state_nxt = region_empty ? S_DONE : S_FILL;
            S_FILL: begin
                if (fill_abort)
                    state_nxt = S_IDLE;
                else if (grant_fill && last_col && last_row)
                    state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM state plus its registered status outputs.
    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            fill_busy <= 1'b0;
            fill_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            fill_busy <= (state_nxt == S_FILL);
            fill_done <= (state == S_DONE);
        end
    end

    // Fill walker: latch the rectangle on start, then step by +1 / row base + H_RES.
    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cur     <= '0;
            y_cur     <= '0;
            x0_q      <= '0;
            x_end_q   <= '0;
            y_end_q   <= '0;
            color_q   <= '0;
            row_base  <= '0;
            fill_addr <= '0;
        end else if (state == S_IDLE && fill_start) begin
            x_cur     <= {1'b0, fill_x0};
            y_cur     <= {1'b0, fill_y0};
            x0_q      <= {1'b0, fill_x0};
            x_end_q   <= x_end_c;
            y_end_q   <= y_end_c;
            color_q   <= fill_color;
            row_base  <= start_row_base;
            fill_addr <= start_row_base + {22'd0, fill_x0};
        end else if (grant_fill) begin
            if (last_col) begin
                x_cur     <= x0_q;
                y_cur     <= y_cur + 11'd1;
                row_base  <= row_base + H_RES32;
                fill_addr <= row_base + H_RES32 + {21'd0, x0_q};
            end else begin
                x_cur     <= x_cur + 11'd1;
                fill_addr <= fill_addr + 32'd1;
            end
        end
    end

    // Write port, CPU handshake and fairness pointer (last_cpu=0 means fill went last).
    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            fb_wr    <= 1'b0;
            fb_addr  <= '0;
            fb_data  <= '0;
            cpu_ack  <= 1'b0;
            err_oob  <= 1'b0;
            last_cpu <= 1'b0;
        end else begin
            fb_wr   <= grant_fill || (grant_cpu && !cpu_oob);
            cpu_ack <= grant_cpu;
            err_oob <= grant_cpu && cpu_oob;
            if (grant_fill) begin
                fb_addr  <= fill_addr;
                fb_data  <= color_q;
                last_cpu <= 1'b0;
            end else if (grant_cpu) begin
                last_cpu <= 1'b1;
                if (!cpu_oob) begin
                    fb_addr <= cpu_addr;
                    fb_data <= cpu_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Bench for fb_write_arbiter: CPU vector table plus fill/contention/abort/reset sequences,
// with every framebuffer write checked against a queue of expected writes.
module tb_fb_write_arbiter;

    logic        cpu_clk = 1'b0;
    logic        rst_n;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_ack;
    logic        fill_start, fill_abort;
    logic [9:0]  fill_x0, fill_y0, fill_w, fill_h;
    logic [7:0]  fill_color;
    logic        fill_busy, fill_done;
    logic        fb_wr;
    logic [31:0] fb_addr;
    logic [7:0]  fb_data;
    logic        err_oob;

    fb_write_arbiter dut (
        .cpu_clk    (cpu_clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_data   (cpu_data),
        .cpu_ack    (cpu_ack),
        .fill_start (fill_start),
        .fill_abort (fill_abort),
        .fill_x0    (fill_x0),
        .fill_y0    (fill_y0),
        .fill_w     (fill_w),
        .fill_h     (fill_h),
        .fill_color (fill_color),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .fb_wr      (fb_wr),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .err_oob    (err_oob)
    );

    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
        logic        oob;
    } cpu_vec_t;

    wr_t cpu_q[$];
    wr_t fill_q[$];
    bit  src_log[$];
    int  tests = 0;
    int  fails = 0;
    int  wr_count = 0;
    int  done_count = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    // Scoreboard: writes carrying the pending fill colour are matched to the fill queue.
    always @(negedge cpu_clk) begin
        wr_t w;
        if (fill_done) done_count++;
        if (fb_wr) begin
            wr_count++;
            if (fill_q.size() > 0 && fb_data == fill_q[0].data) begin
                w = fill_q.pop_front();
                src_log.push_back(1'b1);
                chk("fill_wr_addr", fb_addr, w.addr);
            end else if (cpu_q.size() > 0) begin
                w = cpu_q.pop_front();
                src_log.push_back(1'b0);
                chk("cpu_wr_addr", fb_addr, w.addr);
                chk("cpu_wr_data", {24'd0, fb_data}, {24'd0, w.data});
            end else begin
                tests++;
                fails++;
                $display("FAIL unexpected_wr: addr %0d data 0x%0h, expected no write", fb_addr, fb_data);
            end
        end
    end

    // Reference model: clipped rectangle walked row by row.
    task automatic push_fill(input int x0, input int y0, input int w, input int h, input logic [7:0] c);
        int xe, ye;
        wr_t e;
        xe = (x0 + w > 640) ? 640 : x0 + w;
        ye = (y0 + h > 400) ? 400 : y0 + h;
        for (int y = y0; y < ye; y++)
            for (int x = x0; x < xe; x++) begin
                e.addr = 32'(y * 640 + x);
                e.data = c;
                fill_q.push_back(e);
            end
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [7:0] d, input bit hold,
                             output int lat, output logic oob_seen, output logic wr_seen);
        cpu_addr = a;
        cpu_data = d;
        cpu_req  = 1'b1;
        lat = 0;
        do begin
            @(posedge cpu_clk); #1;
            lat++;
        end while (!cpu_ack && lat < 20);
        oob_seen = err_oob;
        wr_seen  = fb_wr;
        if (hold) begin
            @(posedge cpu_clk); #1;
            cpu_req = 1'b0;
        end
    endtask

    task automatic run_fill(input logic [9:0] x0, input logic [9:0] y0, input logic [9:0] w,
                            input logic [9:0] h, input logic [7:0] c,
                            output int n, output logic busy_first, output int busy_cnt);
        fill_x0 = x0; fill_y0 = y0; fill_w = w; fill_h = h; fill_color = c;
        fill_start = 1'b1;
        n = 0;
        busy_cnt = 0;
        busy_first = 1'b0;
        do begin
            @(posedge cpu_clk); #1;
            fill_start = 1'b0;
            n++;
            if (n == 1) busy_first = fill_busy;
            if (fill_busy) busy_cnt++;
        end while (!fill_done && n < 200);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        cpu_vec_t vecs[6];
        int   lat, n, bc, w0, d0, alt;
        logic oobs, wrs, bf;
        wr_t  e;

        vecs[0] = '{addr: 32'd1234,      data: 8'hE3, oob: 1'b0};
        vecs[1] = '{addr: 32'd0,         data: 8'h00, oob: 1'b0};
        vecs[2] = '{addr: 32'd255999,    data: 8'hFF, oob: 1'b0};
        vecs[3] = '{addr: 32'd256000,    data: 8'h5A, oob: 1'b1};
        vecs[4] = '{addr: 32'hFFFF_FFFF, data: 8'h11, oob: 1'b1};
        vecs[5] = '{addr: 32'd77,        data: 8'h12, oob: 1'b0};

        rst_n = 1'b0; cpu_req = 1'b0; cpu_addr = '0; cpu_data = '0;
        fill_start = 1'b0; fill_abort = 1'b0;
        fill_x0 = '0; fill_y0 = '0; fill_w = '0; fill_h = '0; fill_color = '0;

        repeat (3) @(posedge cpu_clk); #1;
        chk("reset_flags", {27'd0, fb_wr, cpu_ack, fill_busy, fill_done, err_oob}, 32'd0);
        chk("reset_fb_addr", fb_addr, 32'd0);
        chk("reset_fb_data", {24'd0, fb_data}, 32'd0);
        rst_n = 1'b1;
        #2;
        chk("post_release_flags", {27'd0, fb_wr, cpu_ack, fill_busy, fill_done, err_oob}, 32'd0);
        @(posedge cpu_clk); #1;

        // CPU vector table; request held through the ack cycle to probe re-grant.
        for (int i = 0; i < 6; i++) begin
            if (!vecs[i].oob) begin
                e.addr = vecs[i].addr;
                e.data = vecs[i].data;
                cpu_q.push_back(e);
            end
            cpu_write(vecs[i].addr, vecs[i].data, 1'b1, lat, oobs, wrs);
            chk($sformatf("cpu_lat_%0d", i), 32'(lat), 32'd1);
            chk($sformatf("cpu_oob_%0d", i), {31'd0, oobs}, {31'd0, vecs[i].oob});
            chk($sformatf("cpu_fbwr_%0d", i), {31'd0, wrs}, {31'd0, !vecs[i].oob});
            chk($sformatf("cpu_pulse_end_%0d", i), {30'd0, cpu_ack, err_oob}, 32'd0);
        end
        repeat (3) @(posedge cpu_clk); #1;
        chk("cpu_queue_drained", 32'(cpu_q.size()), 32'd0);

        // Corner-clipped fill.
        w0 = wr_count;
        push_fill(638, 399, 4, 4, 8'h1C);
        run_fill(10'd638, 10'd399, 10'd4, 10'd4, 8'h1C, n, bf, bc);
        chk("clip_done_cycle", 32'(n), 32'd4);
        chk("clip_busy_first", {31'd0, bf}, 32'd1);
        chk("clip_busy_cycles", 32'(bc), 32'd2);
        chk("clip_writes", 32'(wr_count - w0), 32'd2);
        @(posedge cpu_clk); #1;
        chk("clip_done_pulse_end", {30'd0, fill_done, fill_busy}, 32'd0);

        // Empty regions: zero width, and origin beyond the right edge.
        w0 = wr_count;
        run_fill(10'd5, 10'd5, 10'd0, 10'd3, 8'h22, n, bf, bc);
        chk("empty_w_done_cycle", 32'(n), 32'd2);
        chk("empty_w_busy", 32'(bc), 32'd0);
        run_fill(10'd700, 10'd0, 10'd5, 10'd5, 8'h23, n, bf, bc);
        chk("empty_x_done_cycle", 32'(n), 32'd2);
        repeat (2) @(posedge cpu_clk); #1;
        chk("empty_writes", 32'(wr_count - w0), 32'd0);

        // Fill against continuous CPU traffic: strict alternation expected.
        w0 = wr_count;
        src_log.delete();
        push_fill(10, 2, 3, 2, 8'h1C);
        for (int i = 0; i < 6; i++) begin
            e.addr = 32'(5000 + i);
            e.data = 8'(8'h80 + i);
            cpu_q.push_back(e);
        end
        fork
            run_fill(10'd10, 10'd2, 10'd3, 10'd2, 8'h1C, n, bf, bc);
            begin
                for (int i = 0; i < 6; i++) begin
                    cpu_write(32'(5000 + i), 8'(8'h80 + i), 1'b0, lat, oobs, wrs);
                    chk($sformatf("contend_cpu_lat_%0d", i), {31'd0, (lat <= 2)}, 32'd1);
                end
                cpu_req = 1'b0;
            end
        join
        @(posedge cpu_clk); #1;
        chk("contend_done_cycle", 32'(n), 32'd13);
        chk("contend_writes", 32'(wr_count - w0), 32'd12);
        alt = 0;
        for (int i = 1; i < src_log.size(); i++)
            if (src_log[i] != src_log[i-1]) alt++;
        chk("contend_alternations", 32'(alt), 32'd11);

        // Abort after three fill writes.
        w0 = wr_count;
        d0 = done_count;
        push_fill(0, 0, 3, 1, 8'h33);
        fill_x0 = 10'd0; fill_y0 = 10'd0; fill_w = 10'd100; fill_h = 10'd1; fill_color = 8'h33;
        fill_start = 1'b1;
        repeat (4) begin
            @(posedge cpu_clk); #1;
            fill_start = 1'b0;
        end
        fill_abort = 1'b1;
        @(posedge cpu_clk); #1;
        fill_abort = 1'b0;
        chk("abort_busy_drop", {31'd0, fill_busy}, 32'd0);
        bc = 0;
        repeat (5) begin
            @(posedge cpu_clk); #1;
            if (fill_busy) bc++;
        end
        chk("abort_busy_after", 32'(bc), 32'd0);
        chk("abort_no_done", 32'(done_count - d0), 32'd0);
        chk("abort_writes", 32'(wr_count - w0), 32'd3);

        // Reset in the middle of a fill.
        w0 = wr_count;
        d0 = done_count;
        push_fill(0, 10, 2, 1, 8'h44);
        fill_x0 = 10'd0; fill_y0 = 10'd10; fill_w = 10'd100; fill_h = 10'd1; fill_color = 8'h44;
        fill_start = 1'b1;
        repeat (3) begin
            @(posedge cpu_clk); #1;
            fill_start = 1'b0;
        end
        @(negedge cpu_clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_flags", {29'd0, fb_wr, fill_busy, fill_done}, 32'd0);
        chk("rst_mid_fb_addr", fb_addr, 32'd0);
        repeat (2) @(posedge cpu_clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge cpu_clk); #1;
        chk("rst_mid_no_done", 32'(done_count - d0), 32'd0);
        chk("rst_mid_writes", 32'(wr_count - w0), 32'd2);

        // After reset the CPU must win the first contention; new fill accepted.
        push_fill(5, 5, 2, 1, 8'h44);
        e.addr = 32'd9000;
        e.data = 8'h99;
        cpu_q.push_back(e);
        fork
            run_fill(10'd5, 10'd5, 10'd2, 10'd1, 8'h44, n, bf, bc);
            begin
                @(posedge cpu_clk); #1;
                cpu_write(32'd9000, 8'h99, 1'b0, lat, oobs, wrs);
                cpu_req = 1'b0;
                chk("first_contend_cpu_lat", 32'(lat), 32'd1);
            end
        join
        chk("first_contend_done_cycle", 32'(n), 32'd5);

        repeat (4) @(posedge cpu_clk); #1;
        chk("queues_drained", 32'(cpu_q.size() + fill_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
